sys_pll_ctrl: RTL and testbench

Reset and lock sequencer for the system PLL, running in the PLL reference-clock domain. It holds the PLL in reset after power-up and waits, with a timeout, for a filtered lock indication. It releases the system reset only after a settle interval, and it re-sequences automatically on lock loss or timeout, up to a retry limit. It sits between the board reset and `sys_pll` and drives the top-level reset tree and status LEDs.

---
 rtl/sys_pll_ctrl.sv | 132 +++++++++++++
 tb/tb_sys_pll_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_pll_ctrl.sv
// Reset and lock sequencer for the system PLL, clocked by the PLL reference clock.
// Holds the PLL in reset, qualifies lock, releases sys_rst after settling, and retries on failure.
module sys_pll_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_FILT     = 4,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int SETTLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_SETTLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int MAX_DUR = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
   localparam int TIMER_W = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
   localparam int FILT_W  = $clog2(LOCK_FILT + 1);

   localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX   = {TIMER_W{1'b1}};
   localparam logic [FILT_W-1:0]  FILT_LAST   = FILT_W'(LOCK_FILT - 1);
   localparam logic [FILT_W-1:0]  FILT_MAX    = FILT_W'(LOCK_FILT);
   localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRIES);

   state_t              st;
   state_t              nxt_st;
   logic [7:0]          nxt_retry;
   logic                attempt_fail;
   logic                state_chg;
   logic [TIMER_W-1:0]  timer;
   logic [FILT_W-1:0]   filt;
   logic                lock_p0;
   logic                lock_p1;
   logic                lock_s;

   // Stage p0/p1: two-flop synchronizer for the asynchronous lock indication
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_p0 <= 1'b0;
         lock_p1 <= 1'b0;
      end else begin
         lock_p0 <= pll_locked;
         lock_p1 <= lock_p0;
      end
   end

   assign lock_s = lock_p1;
   assign state  = st;

   always_comb begin
      nxt_st       = st;
      nxt_retry    = retry_cnt;
      attempt_fail = 1'b0;
      if (restart) begin
         nxt_st    = S_RESET_PLL;
         nxt_retry = 8'd0;
      end else begin
         case (st)
            S_RESET_PLL: if (timer == RST_LAST) nxt_st = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
               // Qualification is checked first so it wins over a coincident timeout
               if (lock_s && (filt == FILT_LAST)) nxt_st = S_SETTLE;
               else if (timer == TIMEOUT_LAST)    attempt_fail = 1'b1;
            end
            S_SETTLE: begin
               if (!lock_s) begin
                  attempt_fail = 1'b1;
               end else if (timer == SETTLE_LAST) begin
                  nxt_st    = S_RUN;
                  nxt_retry = 8'd0;
               end
            end
            S_RUN:   if (!lock_s) nxt_st = S_RESET_PLL;
            S_FAIL:  nxt_st = S_FAIL;
            default: nxt_st = S_RESET_PLL;
         endcase
         if (attempt_fail) begin
            nxt_retry = retry_cnt + 8'd1;
            nxt_st    = (nxt_retry >= RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
         end
      end
   end

   // A restart re-enters RESET_PLL even from RESET_PLL, so it restarts the timer too
   assign state_chg = restart || (nxt_st != st);

   // Stage state: FSM register, shared timer, lock filter and registered outputs
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         st        <= S_RESET_PLL;
         retry_cnt <= 8'd0;
         timer     <= '0;
         filt      <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fail      <= 1'b0;
      end else begin
         st        <= nxt_st;
         retry_cnt <= nxt_retry;
         if (state_chg)               timer <= '0;
         else if (timer != TIMER_MAX) timer <= timer + 1'b1;
         if (state_chg || !lock_s)
            filt <= '0;
         else if ((st == S_WAIT_LOCK) && (filt != FILT_MAX))
            filt <= filt + 1'b1;
         pll_rst <= (nxt_st == S_RESET_PLL) || (nxt_st == S_FAIL);
         sys_rst <= (nxt_st != S_RUN);
         ready   <= (nxt_st == S_RUN);
         fail    <= (nxt_st == S_FAIL);
      end
   end

endmodule

// File: tb/tb_sys_pll_ctrl.sv
// Bench for sys_pll_ctrl: hand-derived checkpoint table for the directed sequences,
// plus randomized lock/restart traffic compared each cycle against a behavioural model.
module tb_sys_pll_ctrl;

   localparam int RC = 4;
   localparam int LF = 3;
   localparam int LT = 100;
   localparam int SC = 8;
   localparam int MR = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst, sys_rst, ready, fail;
   logic [7:0] retry_cnt;
   logic [2:0] state;

   sys_pll_ctrl #(
      .RST_CYCLES(RC), .LOCK_FILT(LF), .LOCK_TIMEOUT(LT),
      .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
      .retry_cnt(retry_cnt), .state(state)
   );

   always #5 refclk = ~refclk;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int         scen;
      int         ed;
      logic [2:0] st;
      logic       prst;
      logic       srst;
      logic       rdy;
      logic       fl;
      logic [7:0] rc;
   } cp_t;
   cp_t cps[$];

   // Behavioural model: phase, edges spent in phase, retries, input history
   int   m_st;
   int   m_n;
   int   m_retry;
   logic hist[$];
   logic lock_run[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_n = 0; m_retry = 0;
      hist.delete(); lock_run.delete();
   endtask

   task automatic model_goto(input int s);
      m_st = s; m_n = 0; lock_run.delete();
   endtask

   task automatic model_edge(input logic lk, input logic rs);
      logic ls;
      int   ones;
      ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(lk);
      if (hist.size() > 2) void'(hist.pop_front());
      m_n++;
      if (rs) begin
         m_retry = 0;
         model_goto(0);
      end else begin
         case (m_st)
            0: if (m_n == RC) model_goto(1);
            1: begin
               lock_run.push_back(ls);
               ones = 0;
               for (int i = lock_run.size() - 1; i >= 0 && lock_run[i]; i--) ones++;
               if (ones >= LF) model_goto(2);
               else if (m_n == LT) begin
                  m_retry++;
                  model_goto((m_retry >= MR) ? 4 : 0);
               end
            end
            2: begin
               if (!ls) begin
                  m_retry++;
                  model_goto((m_retry >= MR) ? 4 : 0);
               end else if (m_n == SC) begin
                  m_retry = 0;
                  model_goto(3);
               end
            end
            3: if (!ls) model_goto(0);
            default: ;
         endcase
      end
   endtask

   function automatic logic [14:0] model_outs();
      return {3'(m_st), (m_st == 0 || m_st == 4), (m_st != 3), (m_st == 3), (m_st == 4), 8'(m_retry)};
   endfunction

   task automatic step(input logic lk, input logic rs);
      pll_locked = lk;
      restart    = rs;
      @(posedge refclk);
      model_edge(lk, rs);
      @(negedge refclk);
      restart = 1'b0;
      check("model", {17'd0, state, pll_rst, sys_rst, ready, fail, retry_cnt}, {17'd0, model_outs()});
   endtask

   task automatic do_reset();
      rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
      @(negedge refclk);
      @(negedge refclk);
      model_reset();
      check("rst_state", 32'(state), 32'd0);
      check("rst_pll_rst", 32'(pll_rst), 32'd1);
      check("rst_sys_rst", 32'(sys_rst), 32'd1);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_fail", 32'(fail), 32'd0);
      check("rst_retry", 32'(retry_cnt), 32'd0);
      rst = 1'b0;
   endtask

   task automatic add_cp(input int s, input int e, input int st, input logic p, input logic sr,
                         input logic r, input logic f, input int rc);
      cps.push_back(cp_t'{s, e, 3'(st), p, sr, r, f, 8'(rc)});
   endtask

   function automatic logic lk_of(input int s, input int e);
      case (s)
         0: return ((e >= 10) && (e < 50)) || (e >= 60);
         1: return (e == 10) || (e == 11) || (e >= 13);
         2: return 1'b0;
         3: return (e >= 10) && (e < 16);
         default: return (e >= 10);
      endcase
   endfunction

   function automatic logic rs_of(input int s, input int e);
      return (s == 2) && ((e == 1208) || (e == 1312));
   endfunction

   task automatic run_scen(input int s, input int len);
      do_reset();
      for (int e = 0; e < len; e++) begin
         step(lk_of(s, e), rs_of(s, e));
         foreach (cps[i]) begin
            if (cps[i].scen == s && cps[i].ed == e) begin
               check($sformatf("s%0d_e%0d_state", s, e), 32'(state), 32'(cps[i].st));
               check($sformatf("s%0d_e%0d_pll_rst", s, e), 32'(pll_rst), 32'(cps[i].prst));
               check($sformatf("s%0d_e%0d_sys_rst", s, e), 32'(sys_rst), 32'(cps[i].srst));
               check($sformatf("s%0d_e%0d_ready", s, e), 32'(ready), 32'(cps[i].rdy));
               check($sformatf("s%0d_e%0d_fail", s, e), 32'(fail), 32'(cps[i].fl));
               check($sformatf("s%0d_e%0d_retry", s, e), 32'(retry_cnt), 32'(cps[i].rc));
            end
         end
      end
   endtask

   initial begin
      // Clean bring-up, lock loss in RUN at edge 50, re-lock
      add_cp(0,  0, 0, 1, 1, 0, 0, 0);
      add_cp(0,  2, 0, 1, 1, 0, 0, 0);
      add_cp(0,  3, 1, 0, 1, 0, 0, 0);
      add_cp(0, 13, 1, 0, 1, 0, 0, 0);
      add_cp(0, 14, 2, 0, 1, 0, 0, 0);
      add_cp(0, 21, 2, 0, 1, 0, 0, 0);
      add_cp(0, 22, 3, 0, 0, 1, 0, 0);
      add_cp(0, 51, 3, 0, 0, 1, 0, 0);
      add_cp(0, 52, 0, 1, 1, 0, 0, 0);
      add_cp(0, 53, 0, 1, 1, 0, 0, 0);
      add_cp(0, 56, 1, 0, 1, 0, 0, 0);
      add_cp(0, 63, 1, 0, 1, 0, 0, 0);
      add_cp(0, 64, 2, 0, 1, 0, 0, 0);
      add_cp(0, 72, 3, 0, 0, 1, 0, 0);
      // Glitchy lock restarts the filter
      add_cp(1, 14, 1, 0, 1, 0, 0, 0);
      add_cp(1, 16, 1, 0, 1, 0, 0, 0);
      add_cp(1, 17, 2, 0, 1, 0, 0, 0);
      add_cp(1, 25, 3, 0, 0, 1, 0, 0);
      // Timeouts into FAIL, hold, restart, restart coinciding with a timeout
      add_cp(2,  102, 1, 0, 1, 0, 0, 0);
      add_cp(2,  103, 0, 1, 1, 0, 0, 1);
      add_cp(2,  107, 1, 0, 1, 0, 0, 1);
      add_cp(2,  206, 1, 0, 1, 0, 0, 1);
      add_cp(2,  207, 4, 1, 1, 0, 1, 2);
      add_cp(2, 1207, 4, 1, 1, 0, 1, 2);
      add_cp(2, 1208, 0, 1, 1, 0, 0, 0);
      add_cp(2, 1311, 1, 0, 1, 0, 0, 0);
      add_cp(2, 1312, 0, 1, 1, 0, 0, 0);
      // Lock loss during SETTLE
      add_cp(3, 17, 2, 0, 1, 0, 0, 0);
      add_cp(3, 18, 0, 1, 1, 0, 0, 1);
      add_cp(3, 22, 1, 0, 1, 0, 0, 1);
      add_cp(4, 22, 3, 0, 0, 1, 0, 0);

      run_scen(0, 80);
      run_scen(1, 30);
      run_scen(2, 1320);
      run_scen(3, 30);
      run_scen(4, 30);

      // Asynchronous reset between edges while in RUN
      #2 rst = 1'b1;
      #1;
      check("async_sys_rst", 32'(sys_rst), 32'd1);
      check("async_ready", 32'(ready), 32'd0);
      check("async_state", 32'(state), 32'd0);
      check("async_pll_rst", 32'(pll_rst), 32'd1);
      model_reset();

      // Randomized lock behaviour and sparse restarts
      do_reset();
      begin
         logic lk;
         int   hold;
         lk = 1'b0;
         hold = 0;
         for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
               lk   = ($urandom_range(0, 2) != 0);
               hold = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 250) : $urandom_range(1, 12);
            end
            hold--;
            step(lk, ($urandom_range(0, 299) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
